// File: rtl/maxpool2x2_stream.sv
// 2x2 stride-2 max pooling over a raster-order IEEE-754 single-precision stream.
// Optional ReLU is applied to the pooled result. Trailing odd row/column is ignored.
module maxpool2x2_stream #(
   parameter int DATA_WIDTH = 32,
   parameter int WIDTH      = 8,
   parameter int HEIGHT     = 8,
   parameter int RELU       = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] i_data,
   input  logic                  valid_in,
   output logic [DATA_WIDTH-1:0] o_data,
   output logic                  valid_out,
   output logic [15:0]           o_col,
   output logic [15:0]           o_row,
   output logic                  frame_done
);
   // Handshake: valid-only. A pixel is consumed on every clock where valid_in is high;
   // there is no ready, so no backpressure. valid_out is a one-cycle pulse per pooled pixel.

   localparam int          HALF_W    = WIDTH / 2;
   localparam int          HALF_H    = HEIGHT / 2;
   localparam int          IDX_W     = (HALF_W > 1) ? $clog2(HALF_W) : 1;
   localparam int          MSB       = DATA_WIDTH - 1;
   localparam logic [15:0] LAST_COL  = 16'(WIDTH - 1);
   localparam logic [15:0] LAST_ROW  = 16'(HEIGHT - 1);
   localparam logic [15:0] POOL_COLS = 16'(2 * HALF_W);
   localparam logic [15:0] POOL_ROWS = 16'(2 * HALF_H);
   localparam logic [15:0] LAST_PCOL = 16'(HALF_W - 1);
   localparam logic [15:0] LAST_PROW = 16'(HALF_H - 1);

   // Max on raw float bits: sign-magnitude ordering, +0 beats -0 via the sign rule.
   function automatic logic [DATA_WIDTH-1:0] fmax(input logic [DATA_WIDTH-1:0] a,
                                                  input logic [DATA_WIDTH-1:0] b);
      logic [DATA_WIDTH-1:0] res;
      if (a[MSB] != b[MSB])
         res = a[MSB] ? b : a;
      else if (!a[MSB])
         res = (a > b) ? a : b;
      else
         res = (a < b) ? a : b;
      return res;
   endfunction

   logic [15:0]           col;
   logic [15:0]           row;
   logic [DATA_WIDTH-1:0] left;
   logic [DATA_WIDTH-1:0] line_buf [HALF_W];
   logic [IDX_W-1:0]      buf_idx;
   logic [DATA_WIDTH-1:0] pair_max;
   logic [DATA_WIDTH-1:0] pooled;
   logic [DATA_WIDTH-1:0] relu_out;
   logic                  in_region;
   logic                  last_col;
   logic                  last_row;

   assign buf_idx   = col[IDX_W:1];
   assign in_region = (col < POOL_COLS) && (row < POOL_ROWS);
   assign last_col  = (col == LAST_COL);
   assign last_row  = (row == LAST_ROW);
   assign pair_max  = fmax(left, i_data);
   assign pooled    = fmax(line_buf[buf_idx], pair_max);
   assign relu_out  = ((RELU != 0) && pooled[MSB]) ? '0 : pooled;

   always_ff @(posedge clk) begin
      if (rst) begin
         col        <= '0;
         row        <= '0;
         left       <= '0;
         o_data     <= '0;
         valid_out  <= 1'b0;
         o_col      <= '0;
         o_row      <= '0;
         frame_done <= 1'b0;
      end else begin
         valid_out  <= 1'b0;
         frame_done <= 1'b0;
         if (valid_in) begin
            if (last_col) begin
               col <= '0;
               row <= last_row ? 16'd0 : row + 16'd1;
            end else begin
               col <= col + 16'd1;
            end
            if (in_region && !col[0])
               left <= i_data;
            // Bottom-right pixel of a window: emit the pooled result next cycle.
            if (in_region && col[0] && row[0]) begin
               o_data     <= relu_out;
               valid_out  <= 1'b1;
               o_col      <= col >> 1;
               o_row      <= row >> 1;
               frame_done <= ((col >> 1) == LAST_PCOL) && ((row >> 1) == LAST_PROW);
            end
         end
      end
   end

   // Line buffer keeps the top-row pair maxima; contents are don't-care after reset.
   always_ff @(posedge clk) begin
      if (!rst && valid_in && in_region && col[0] && !row[0])
         line_buf[buf_idx] <= pair_max;
   end

endmodule

// File: tb/tb_maxpool2x2_stream.sv
// Bench for maxpool2x2_stream: three configurations share one input stream and each
// is compared every cycle against a frame-array reference model.
module tb_maxpool2x2_stream;
   localparam int NC = 3;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                     rst = 1'b1;
   logic                     valid_in = 1'b0;
   logic [31:0]              i_data = '0;
   logic [NC-1:0][31:0]      o_data;
   logic [NC-1:0][15:0]      o_col;
   logic [NC-1:0][15:0]      o_row;
   logic [NC-1:0]            valid_out;
   logic [NC-1:0]            frame_done;

   maxpool2x2_stream #(.DATA_WIDTH(32), .WIDTH(4), .HEIGHT(4), .RELU(0)) u0 (
      .clk(clk), .rst(rst), .i_data(i_data), .valid_in(valid_in), .o_data(o_data[0]),
      .valid_out(valid_out[0]), .o_col(o_col[0]), .o_row(o_row[0]), .frame_done(frame_done[0]));
   maxpool2x2_stream #(.DATA_WIDTH(32), .WIDTH(4), .HEIGHT(4), .RELU(1)) u1 (
      .clk(clk), .rst(rst), .i_data(i_data), .valid_in(valid_in), .o_data(o_data[1]),
      .valid_out(valid_out[1]), .o_col(o_col[1]), .o_row(o_row[1]), .frame_done(frame_done[1]));
   maxpool2x2_stream #(.DATA_WIDTH(32), .WIDTH(7), .HEIGHT(7), .RELU(0)) u2 (
      .clk(clk), .rst(rst), .i_data(i_data), .valid_in(valid_in), .o_data(o_data[2]),
      .valid_out(valid_out[2]), .o_col(o_col[2]), .o_row(o_row[2]), .frame_done(frame_done[2]));

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model state
   int          cfg_w    [NC] = '{4, 4, 7};
   int          cfg_h    [NC] = '{4, 4, 7};
   int          cfg_relu [NC] = '{0, 1, 0};
   logic [31:0] frame_pix [NC][8][8];
   int          m_row [NC];
   int          m_col [NC];
   logic        exp_valid [NC];
   logic        exp_fd    [NC];
   logic [31:0] exp_data  [NC];
   logic [15:0] exp_col   [NC];
   logic [15:0] exp_row   [NC];

   // Scoreboard of observed pooled outputs, plus fixed expectations
   logic [31:0] out_q [NC][$];
   logic [15:0] row_q [$];
   int          fd_cnt [NC];
   logic [31:0] exp_q [$];

   function automatic longint fkey(input logic [31:0] x);
      return x[31] ? -longint'(x[30:0]) : longint'(x[30:0]);
   endfunction

   // Strictly greater in real-number order; +0 counts as greater than -0.
   function automatic bit fgreater(input logic [31:0] a, input logic [31:0] b);
      return (fkey(a) > fkey(b)) || ((fkey(a) == fkey(b)) && !a[31] && b[31]);
   endfunction

   function automatic logic [31:0] int_to_f(input int n);
      int e;
      logic [22:0] man;
      e = 0;
      while ((n >> (e + 1)) != 0) e++;
      man = 23'((n - (1 << e)) << (23 - e));
      return {1'b0, 8'(127 + e), man};
   endfunction

   function automatic logic [31:0] rand_f();
      return {1'($urandom_range(0, 1)), 8'(120 + $urandom_range(0, 12)), 23'($urandom)};
   endfunction

   task automatic model_step(input logic r, input logic v, input logic [31:0] d);
      logic [31:0] best;
      int rr, cc;
      for (int k = 0; k < NC; k++) begin
         exp_valid[k] = 1'b0;
         exp_fd[k]    = 1'b0;
         if (r) begin
            m_row[k] = 0; m_col[k] = 0;
            exp_data[k] = '0; exp_col[k] = '0; exp_row[k] = '0;
         end else if (v) begin
            rr = m_row[k]; cc = m_col[k];
            frame_pix[k][rr][cc] = d;
            if ((rr % 2 == 1) && (cc % 2 == 1) && (rr < (cfg_h[k] / 2) * 2) && (cc < (cfg_w[k] / 2) * 2)) begin
               best = frame_pix[k][rr-1][cc-1];
               if (fgreater(frame_pix[k][rr-1][cc], best)) best = frame_pix[k][rr-1][cc];
               if (fgreater(frame_pix[k][rr][cc-1], best)) best = frame_pix[k][rr][cc-1];
               if (fgreater(frame_pix[k][rr][cc], best))   best = frame_pix[k][rr][cc];
               exp_valid[k] = 1'b1;
               exp_data[k]  = (cfg_relu[k] != 0 && best[31]) ? 32'h0 : best;
               exp_col[k]   = 16'(cc / 2);
               exp_row[k]   = 16'(rr / 2);
               exp_fd[k]    = (cc / 2 == cfg_w[k] / 2 - 1) && (rr / 2 == cfg_h[k] / 2 - 1);
            end
            if (cc == cfg_w[k] - 1) begin
               m_col[k] = 0;
               m_row[k] = (rr == cfg_h[k] - 1) ? 0 : rr + 1;
            end else begin
               m_col[k] = cc + 1;
            end
         end
      end
   endtask

   // Drive one cycle of stimulus, advance the model, sample 1 time unit after the edge.
   task automatic drive(input logic r, input logic v, input logic [31:0] d);
      rst = r; valid_in = v; i_data = d;
      model_step(r, v, d);
      @(posedge clk);
      #1;
   endtask

   task automatic clear_sb();
      for (int k = 0; k < NC; k++) begin
         out_q[k].delete();
         fd_cnt[k] = 0;
      end
      row_q.delete();
   endtask

   task automatic test_reset();
      for (int i = 0; i < 6; i++) begin
         drive(i < 3, 1'b1, rand_f());
         for (int k = 0; k < NC; k++) begin
            n_tests++;
            if (valid_out[k] !== exp_valid[k] || frame_done[k] !== exp_fd[k] || o_data[k] !== exp_data[k] ||
                o_col[k] !== exp_col[k] || o_row[k] !== exp_row[k]) begin
               n_fail++;
               $display("FAIL reset dut%0d cyc%0d: got v=%b fd=%b d=%h c=%0d r=%0d want v=%b fd=%b d=%h c=%0d r=%0d",
                        k, i, valid_out[k], frame_done[k], o_data[k], o_col[k], o_row[k],
                        exp_valid[k], exp_fd[k], exp_data[k], exp_col[k], exp_row[k]);
            end
         end
         if (i < 3) begin
            n_tests++;
            if (valid_out !== 3'b000 || o_data[0] !== 32'h0 || o_row[2] !== 16'h0) begin
               n_fail++;
               $display("FAIL reset_zero: got valid=%b data=%h want valid=000 data=0", valid_out, o_data[0]);
            end
         end
      end
   endtask

   task automatic test_basic();
      drive(1'b1, 1'b0, 32'h0);
      clear_sb();
      for (int i = 0; i < 16; i++) begin
         drive(1'b0, 1'b1, int_to_f(i + 1));
         for (int k = 0; k < NC; k++) begin
            n_tests++;
            if (valid_out[k] !== exp_valid[k] || frame_done[k] !== exp_fd[k] || o_data[k] !== exp_data[k] ||
                o_col[k] !== exp_col[k] || o_row[k] !== exp_row[k]) begin
               n_fail++;
               $display("FAIL basic dut%0d px%0d: got v=%b fd=%b d=%h c=%0d r=%0d want v=%b fd=%b d=%h c=%0d r=%0d",
                        k, i, valid_out[k], frame_done[k], o_data[k], o_col[k], o_row[k],
                        exp_valid[k], exp_fd[k], exp_data[k], exp_col[k], exp_row[k]);
            end
            if (valid_out[k] === 1'b1) out_q[k].push_back(o_data[k]);
            if (frame_done[k] === 1'b1) fd_cnt[k]++;
         end
      end
      drive(1'b0, 1'b0, 32'h0);
      exp_q = '{32'h40C00000, 32'h41000000, 32'h41600000, 32'h41800000};
      n_tests++;
      if (out_q[0].size() != 4) begin
         n_fail++;
         $display("FAIL basic_count: got %0d outputs want 4", out_q[0].size());
      end
      for (int j = 0; j < 4; j++) begin
         n_tests++;
         if (out_q[0][j] !== exp_q[j]) begin
            n_fail++;
            $display("FAIL basic_value%0d: got %h want %h", j, out_q[0][j], exp_q[j]);
         end
      end
      n_tests++;
      if (fd_cnt[0] != 1) begin
         n_fail++;
         $display("FAIL basic_frame_done: got %0d pulses want 1", fd_cnt[0]);
      end
   endtask

   task automatic test_sign();
      logic [31:0] px [16];
      for (int i = 0; i < 16; i++) px[i] = rand_f();
      px[0] = 32'hC0400000; px[1] = 32'hBF800000; px[4] = 32'hC0000000; px[5] = 32'h80000000;
      px[2] = 32'hC0A00000; px[3] = 32'h40000000; px[6] = 32'hBF800000; px[7] = 32'h3F000000;
      drive(1'b1, 1'b0, 32'h0);
      clear_sb();
      for (int i = 0; i < 16; i++) begin
         drive(1'b0, 1'b1, px[i]);
         for (int k = 0; k < NC; k++) begin
            n_tests++;
            if (valid_out[k] !== exp_valid[k] || frame_done[k] !== exp_fd[k] || o_data[k] !== exp_data[k] ||
                o_col[k] !== exp_col[k] || o_row[k] !== exp_row[k]) begin
               n_fail++;
               $display("FAIL sign dut%0d px%0d: got v=%b fd=%b d=%h c=%0d r=%0d want v=%b fd=%b d=%h c=%0d r=%0d",
                        k, i, valid_out[k], frame_done[k], o_data[k], o_col[k], o_row[k],
                        exp_valid[k], exp_fd[k], exp_data[k], exp_col[k], exp_row[k]);
            end
            if (valid_out[k] === 1'b1) out_q[k].push_back(o_data[k]);
         end
      end
      n_tests++;
      if (out_q[0].size() < 2 || out_q[0][0] !== 32'h80000000 || out_q[0][1] !== 32'h40000000) begin
         n_fail++;
         $display("FAIL sign_norelu: got %h %h want 80000000 40000000", out_q[0][0], out_q[0][1]);
      end
      n_tests++;
      if (out_q[1].size() < 2 || out_q[1][0] !== 32'h00000000 || out_q[1][1] !== 32'h40000000) begin
         n_fail++;
         $display("FAIL sign_relu: got %h %h want 00000000 40000000", out_q[1][0], out_q[1][1]);
      end
   endtask

   task automatic test_odd_dims();
      logic [31:0] v;
      drive(1'b1, 1'b0, 32'h0);
      clear_sb();
      for (int i = 0; i < 49; i++) begin
         v = (i / 7 == 6 || i % 7 == 6) ? 32'h42C80000 : rand_f();
         drive(1'b0, 1'b1, v);
         for (int k = 0; k < NC; k++) begin
            n_tests++;
            if (valid_out[k] !== exp_valid[k] || frame_done[k] !== exp_fd[k] || o_data[k] !== exp_data[k] ||
                o_col[k] !== exp_col[k] || o_row[k] !== exp_row[k]) begin
               n_fail++;
               $display("FAIL odd dut%0d px%0d: got v=%b fd=%b d=%h c=%0d r=%0d want v=%b fd=%b d=%h c=%0d r=%0d",
                        k, i, valid_out[k], frame_done[k], o_data[k], o_col[k], o_row[k],
                        exp_valid[k], exp_fd[k], exp_data[k], exp_col[k], exp_row[k]);
            end
            if (valid_out[k] === 1'b1) out_q[k].push_back(o_data[k]);
            if (frame_done[k] === 1'b1) fd_cnt[k]++;
         end
      end
      drive(1'b0, 1'b0, 32'h0);
      n_tests++;
      if (out_q[2].size() != 9 || fd_cnt[2] != 1) begin
         n_fail++;
         $display("FAIL odd_count: got %0d outputs %0d frame_done want 9 and 1", out_q[2].size(), fd_cnt[2]);
      end
      foreach (out_q[2][j]) begin
         n_tests++;
         if (out_q[2][j] === 32'h42C80000) begin
            n_fail++;
            $display("FAIL odd_ignored%0d: got %h want any value other than 42c80000", j, out_q[2][j]);
         end
      end
   endtask

   task automatic test_gaps();
      int px;
      drive(1'b1, 1'b0, 32'h0);
      clear_sb();
      px = 0;
      for (int cyc = 0; cyc < 200 && px < 16; cyc++) begin
         if ($urandom_range(0, 1) == 1) begin
            drive(1'b0, 1'b1, int_to_f(px + 1));
            px++;
         end else begin
            drive(1'b0, 1'b0, rand_f());
         end
         for (int k = 0; k < NC; k++) begin
            n_tests++;
            if (valid_out[k] !== exp_valid[k] || frame_done[k] !== exp_fd[k] || o_data[k] !== exp_data[k] ||
                o_col[k] !== exp_col[k] || o_row[k] !== exp_row[k]) begin
               n_fail++;
               $display("FAIL gaps dut%0d cyc%0d: got v=%b fd=%b d=%h c=%0d r=%0d want v=%b fd=%b d=%h c=%0d r=%0d",
                        k, cyc, valid_out[k], frame_done[k], o_data[k], o_col[k], o_row[k],
                        exp_valid[k], exp_fd[k], exp_data[k], exp_col[k], exp_row[k]);
            end
            if (valid_out[k] === 1'b1) out_q[k].push_back(o_data[k]);
         end
      end
      exp_q = '{32'h40C00000, 32'h41000000, 32'h41600000, 32'h41800000};
      n_tests++;
      if (px != 16 || out_q[0].size() != 4) begin
         n_fail++;
         $display("FAIL gaps_count: got %0d pixels %0d outputs want 16 and 4", px, out_q[0].size());
      end
      for (int j = 0; j < 4; j++) begin
         n_tests++;
         if (out_q[0][j] !== exp_q[j]) begin
            n_fail++;
            $display("FAIL gaps_value%0d: got %h want %h", j, out_q[0][j], exp_q[j]);
         end
      end
   endtask

   task automatic test_reset_mid();
      drive(1'b1, 1'b0, 32'h0);
      for (int i = 0; i < 25; i++) begin
         if (i < 8)       drive(1'b0, 1'b1, int_to_f(i + 1));
         else if (i == 8) drive(1'b1, 1'b1, 32'h42C80000);
         else             drive(1'b0, 1'b1, int_to_f(i - 8));
         if (i == 8) clear_sb();
         for (int k = 0; k < NC; k++) begin
            n_tests++;
            if (valid_out[k] !== exp_valid[k] || frame_done[k] !== exp_fd[k] || o_data[k] !== exp_data[k] ||
                o_col[k] !== exp_col[k] || o_row[k] !== exp_row[k]) begin
               n_fail++;
               $display("FAIL rstmid dut%0d cyc%0d: got v=%b fd=%b d=%h c=%0d r=%0d want v=%b fd=%b d=%h c=%0d r=%0d",
                        k, i, valid_out[k], frame_done[k], o_data[k], o_col[k], o_row[k],
                        exp_valid[k], exp_fd[k], exp_data[k], exp_col[k], exp_row[k]);
            end
            if (valid_out[k] === 1'b1) out_q[k].push_back(o_data[k]);
         end
      end
      exp_q = '{32'h40C00000, 32'h41000000, 32'h41600000, 32'h41800000};
      n_tests++;
      if (out_q[0].size() != 4) begin
         n_fail++;
         $display("FAIL rstmid_count: got %0d outputs want 4", out_q[0].size());
      end
      for (int j = 0; j < 4; j++) begin
         n_tests++;
         if (out_q[0][j] !== exp_q[j]) begin
            n_fail++;
            $display("FAIL rstmid_value%0d: got %h want %h", j, out_q[0][j], exp_q[j]);
         end
      end
   endtask

   task automatic test_back_to_back();
      drive(1'b1, 1'b0, 32'h0);
      clear_sb();
      for (int i = 0; i < 32; i++) begin
         drive(1'b0, 1'b1, rand_f());
         for (int k = 0; k < NC; k++) begin
            n_tests++;
            if (valid_out[k] !== exp_valid[k] || frame_done[k] !== exp_fd[k] || o_data[k] !== exp_data[k] ||
                o_col[k] !== exp_col[k] || o_row[k] !== exp_row[k]) begin
               n_fail++;
               $display("FAIL b2b dut%0d px%0d: got v=%b fd=%b d=%h c=%0d r=%0d want v=%b fd=%b d=%h c=%0d r=%0d",
                        k, i, valid_out[k], frame_done[k], o_data[k], o_col[k], o_row[k],
                        exp_valid[k], exp_fd[k], exp_data[k], exp_col[k], exp_row[k]);
            end
            if (valid_out[k] === 1'b1) out_q[k].push_back(o_data[k]);
            if (frame_done[k] === 1'b1) fd_cnt[k]++;
         end
         if (valid_out[0] === 1'b1) row_q.push_back(o_row[0]);
      end
      n_tests++;
      if (out_q[0].size() != 8 || fd_cnt[0] != 2) begin
         n_fail++;
         $display("FAIL b2b_count: got %0d outputs %0d frame_done want 8 and 2", out_q[0].size(), fd_cnt[0]);
      end
      n_tests++;
      if (row_q.size() < 5 || row_q[3] !== 16'd1 || row_q[4] !== 16'd0) begin
         n_fail++;
         $display("FAIL b2b_row_wrap: got rows %0d,%0d want 1,0", row_q[3], row_q[4]);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_sign();
      test_odd_dims();
      test_gaps();
      test_reset_mid();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
